div_seq: RTL and testbench

- Multi-cycle sequencer for 32-bit DIV/DIVU. One restoring quotient bit per clock.
- Sits beside the EX stage. EX holds start_i while a divide is in EX and stalls the pipeline until ready_o.
- Result is written to HI/LO as {remainder, quotient}.
- Owns the iteration counter, the operand/partial-remainder registers, sign correction and the annul handling used for flushes.

---
 rtl/div_seq.sv | 156 +++++++++++++++
 tb/tb_div_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider for 32-bit DIV/DIVU.
// Produces one quotient bit per clock and returns {remainder, quotient}.
// It sits beside EX, which holds start_i and stalls until ready_o.
//
// Handshake: start_i is a level request.
//   - EX raises it with the operands and keeps it high until it sees ready_o.
//   - The operands and signed_div_i are sampled only on the IDLE edge that
//     accepts the request.
//   - ready_o stays high, with result_o stable, while start_i is held. It
//     drops on the edge after start_i falls.
//   - annul_i overrides start_i in every state and discards work in flight.
// The debug outputs expose the FSM state and the iteration counter.
// State encoding: 0=IDLE, 1=BYZERO, 2=ON, 3=END.
module div_seq #(
  parameter int WIDTH = 32,
  localparam int CW = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic [1:0]         dbg_state,
  output logic [CW-1:0]      dbg_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvd_q;   // dividend magnitude, shifted out MSB first
  logic [WIDTH-1:0] dvs_q;   // divisor magnitude
  logic [WIDTH-1:0] rem_q;   // partial remainder (always below the divisor)
  logic [WIDTH-1:0] quot_q;  // quotient bits collected so far
  logic             q_neg;
  logic             r_neg;

  logic             op1_neg;
  logic             op2_neg;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quot_next;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             last_iter;

  // Operand magnitudes plus one restoring step: shift, trial subtract,
  // and sign correction of the final values.
  always_comb begin
    op1_neg   = signed_div_i & opdata1_i[WIDTH-1];
    op2_neg   = signed_div_i & opdata2_i[WIDTH-1];
    mag1      = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
    mag2      = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;
    rem_shift = {rem_q, dvd_q[WIDTH-1]};
    diff      = rem_shift - {1'b0, dvs_q};
    // The difference fits in WIDTH+1 bits, so its top bit is the borrow.
    q_bit     = ~diff[WIDTH];
    rem_next  = q_bit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quot_next = {quot_q[WIDTH-2:0], q_bit};
    // Negating 0x80000000 wraps to itself, so MIN / -1 needs no special case.
    q_fix     = q_neg ? (~quot_next + 1'b1) : quot_next;
    r_fix     = r_neg ? (~rem_next + 1'b1) : rem_next;
    last_iter = (count == CW'(WIDTH - 1));
  end

  // Sequencer FSM: all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_o <= 1'b0;
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= BYZERO;
            end else begin
              state  <= ON;
              dvd_q  <= mag1;
              dvs_q  <= mag2;
              q_neg  <= op1_neg ^ op2_neg;
              r_neg  <= op1_neg;
              count  <= '0;
              rem_q  <= '0;
              quot_q <= '0;
            end
          end
        end
        BYZERO: begin
          if (annul_i) begin
            state   <= IDLE;
            ready_o <= 1'b0;
          end else begin
            state    <= END;
            result_o <= '0;
            ready_o  <= 1'b1;
          end
        end
        ON: begin
          if (annul_i) begin
            state   <= IDLE;
            ready_o <= 1'b0;
          end else begin
            rem_q  <= rem_next;
            quot_q <= quot_next;
            dvd_q  <= {dvd_q[WIDTH-2:0], 1'b0};
            count  <= count + 1'b1;
            if (last_iter) begin
              result_o <= {r_fix, q_fix};
              state    <= END;
              ready_o  <= 1'b1;
            end
          end
        end
        END: begin
          if (start_i && !annul_i) begin
            ready_o <= 1'b1;
          end else begin
            state   <= IDLE;
            ready_o <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          ready_o <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;
  assign dbg_count = count;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: random and directed DIV/DIVU checks against an arithmetic model.
module tb_div_seq;

  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic           start_i;
  logic           annul_i;
  logic           signed_div_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic [1:0]     dbg_state;
  logic [5:0]     dbg_count;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_res;

  div_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i),
    .signed_div_i(signed_div_i), .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .result_o(result_o), .ready_o(ready_o),
    .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: plain 64-bit integer division.
  // SystemVerilog / and % truncate toward zero, and the remainder takes the
  // dividend's sign.
  function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return 64'd0;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Wait for the next edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: request, wait for ready, check latency and result,
  // hold for one cycle, then release.
  task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b, input string tag);
    int n;
    int exp_lat;
    exp_q.push_back(model(sg, a, b));
    exp_lat      = (b == 0) ? 2 : W + 1;
    start_i      = 1'b1;
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    tick();
    n = 1;
    // Operands are ignored once accepted; scramble them.
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~sg;
    while (!ready_o && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    last_res = exp_q.pop_front();
    check({tag, "_res"}, result_o, last_res);
    tick();
    check({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
    check({tag, "_hold_res"}, result_o, last_res);
    start_i = 1'b0;
    tick();
    check({tag, "_drop_rdy"}, 64'(ready_o), 64'd0);
  endtask

  // Raise the request, then wait until the counter reaches cnt.
  // Stops early if the cycle budget runs out.
  task automatic start_and_wait(input logic [31:0] a, input logic [31:0] b, input int cnt, input string tag);
    int n;
    start_i      = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = a;
    opdata2_i    = b;
    tick();
    n = 0;
    while (!(dbg_state == 2'd2 && dbg_count == 6'(cnt)) && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_reach"}, 64'(n < 100), 64'd1);
  endtask

  initial begin
    logic sg;
    logic [31:0] a, b;
    int ready_seen;
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    tick(); tick();
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_result", result_o, 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    tick();

    // Directed cases
    run_div(1'b0, 32'd100, 32'd7, "divu_100_7");
    check("divu_100_7_const", last_res, {32'd2, 32'd14});
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, "div_m7_2");
    check("div_m7_2_const", last_res, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, "div_7_m2");
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, "div_min_m1");
    check("div_min_m1_const", last_res, {32'd0, 32'h80000000});
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, "divu_max_1");
    run_div(1'b0, 32'd5, 32'd9, "divu_5_9");
    run_div(1'b0, 32'd1234, 32'd0, "divu_by0");
    run_div(1'b1, 32'hFFFFFF00, 32'd0, "div_by0");

    // A result that is nonzero, so the annul case can prove it is kept.
    run_div(1'b1, 32'hFFFFF000, 32'd7, "div_pre_annul");
    start_and_wait(32'd100, 32'd7, 10, "annul");
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    check("annul_state", 64'(dbg_state), 64'd0);
    ready_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready_o) ready_seen = 1;
      tick();
    end
    check("annul_no_ready", 64'(ready_seen), 64'd0);
    check("annul_result_kept", result_o, last_res);
    run_div(1'b0, 32'd50, 32'd5, "divu_50_5");

    // Simultaneous start and annul in IDLE: annul wins.
    start_i = 1'b1;
    annul_i = 1'b1;
    opdata1_i = 32'd10;
    opdata2_i = 32'd3;
    tick(); tick();
    check("start_annul_state", 64'(dbg_state), 64'd0);
    check("start_annul_ready", 64'(ready_o), 64'd0);
    start_i = 1'b0;
    annul_i = 1'b0;
    tick();

    // Reset in the middle of an operation.
    start_and_wait(32'd1000, 32'd13, 20, "midrst");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start_i = 1'b0;
    check("midrst_state", 64'(dbg_state), 64'd0);
    check("midrst_ready", 64'(ready_o), 64'd0);
    check("midrst_result", result_o, 64'd0);
    tick();
    run_div(1'b0, 32'd9, 32'd3, "divu_9_3");

    // Random operands, with small and zero divisors mixed in.
    for (int i = 0; i < 40; i++) begin
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 20));
        1: b = 32'hFFFFFFFF - 32'($urandom_range(0, 20));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_div(sg, a, b, "rand");
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
